// File: rtl/image_send_pkg.sv
// Shared types and constants for the image send sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: sequencer state enum with its fixed output codes, default trigger
// state, and a small max helper used to size the shared timer.
package image_send_pkg;

  // Encodings are visible on the seq_state port, so they are pinned explicitly.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_GAP    = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_e;

  localparam logic [3:0] TABLE_STATE_DEFAULT = 4'b0100;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/image_send_timer.sv
// Loadable saturating down-counter shared by every timed phase of the sequencer.
// Latency: loaded value visible the cycle after start_i; expired_o is combinational on the count.
// Backpressure: none; start_i always wins over counting.
// Ports: clk, rst (async active-high), start_i (load strobe), load_i (value to load),
//        expired_o (high while the count sits at zero).
module image_send_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] load_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;

  // Holds at zero instead of wrapping so an idle timer reads as expired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= load_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/image_send_sequencer.sv
// Sends NUM_SRC image sources to the Arduino one after another while the robot sits in TABLE_STATE.
// Latency: state/control outputs registered (one cycle after the sampled cause); data_out muxed from the registered index.
// Backpressure: none; image_ready is the only handshake and is ignored while sender_reset is held.
// Ports: clk, reset (async active-high), pix_in (packed sources, source k at [k*PIX_W +: PIX_W]),
//        state (robot state), image_ready (frame received), data_out (selected pixel),
//        sender_reset, seq_state (0 IDLE,1 SEND,2 GAP,3 FINISH), src_idx, done (pulse), timeout_err (sticky).
// Optional feature: define IMAGE_SEND_TIMEOUT_EN to give up on a source after TIMEOUT_TIME silent cycles.
module image_send_sequencer
  import image_send_pkg::*;
#(
  parameter int         PIX_W        = 12,
  parameter int         NUM_SRC      = 2,
  parameter int         WAIT_TIME    = 50_000_000,
  parameter int         RESET_TIME   = 50_000_000,
  parameter int         TIMEOUT_TIME = 500_000_000,
  parameter logic [3:0] TABLE_STATE  = TABLE_STATE_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_SRC*PIX_W-1:0]     pix_in,
  input  logic [3:0]                   state,
  input  logic                         image_ready,
  output logic [PIX_W-1:0]             data_out,
  output logic                         sender_reset,
  output logic [1:0]                   seq_state,
  output logic [$clog2(NUM_SRC):0]     src_idx,
  output logic                         done,
  output logic                         timeout_err
);

  localparam int SRC_W = $clog2(NUM_SRC) + 1;
`ifdef IMAGE_SEND_TIMEOUT_EN
  localparam int unsigned MAX_T = max_u(max_u(WAIT_TIME, RESET_TIME), TIMEOUT_TIME);
`else
  localparam int unsigned MAX_T = max_u(WAIT_TIME, RESET_TIME);
`endif
  localparam int CNT_W = $clog2(MAX_T) + 1;

  // The timer expires on the cycle its count is zero, so loading N-1 yields N cycles.
  localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_TIME - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_TIME - 1);
`ifdef IMAGE_SEND_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_TIME - 1);
`endif
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);

  seq_state_e       state_q, state_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic             sr_q, sr_d;
  logic             done_q, done_d;
`ifdef IMAGE_SEND_TIMEOUT_EN
  logic             terr_q, terr_d;
`endif
  logic             tmr_start;
  logic [CNT_W-1:0] tmr_load;
  logic             tmr_expired;
  logic             trig;

  assign trig = (state == TABLE_STATE);

  image_send_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst       (reset),
    .start_i   (tmr_start),
    .load_i    (tmr_load),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    sr_d      = sr_q;
    done_d    = 1'b0;
    tmr_start = 1'b0;
    tmr_load  = RESET_LOAD;
`ifdef IMAGE_SEND_TIMEOUT_EN
    terr_d    = terr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        src_d = '0;
        sr_d  = 1'b1;
`ifdef IMAGE_SEND_TIMEOUT_EN
        terr_d = 1'b0;
`endif
        if (trig) begin
          state_d   = ST_SEND;
          tmr_start = 1'b1;
          tmr_load  = RESET_LOAD;
        end
      end
      ST_SEND: begin
        if (!trig) begin
          state_d = ST_IDLE;
          src_d   = '0;
          sr_d    = 1'b1;
        end else if (sr_q) begin
          // Reset hold: image_ready is deliberately not looked at here.
          if (tmr_expired) begin
            sr_d = 1'b0;
`ifdef IMAGE_SEND_TIMEOUT_EN
            tmr_start = 1'b1;
            tmr_load  = TIMEOUT_LOAD;
`endif
          end
        end else if (image_ready) begin
          sr_d = 1'b1;
          if (src_q < LAST_SRC) begin
            state_d   = ST_GAP;
            tmr_start = 1'b1;
            tmr_load  = WAIT_LOAD;
          end else begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end
        end
`ifdef IMAGE_SEND_TIMEOUT_EN
        else if (tmr_expired) begin
          state_d = ST_FINISH;
          sr_d    = 1'b1;
          terr_d  = 1'b1;
        end
`endif
      end
      ST_GAP: begin
        if (!trig) begin
          state_d = ST_IDLE;
          src_d   = '0;
        end else if (tmr_expired) begin
          state_d   = ST_SEND;
          src_d     = src_q + SRC_W'(1);
          tmr_start = 1'b1;
          tmr_load  = RESET_LOAD;
        end
      end
      ST_FINISH: begin
        if (!trig) begin
          state_d = ST_IDLE;
          src_d   = '0;
`ifdef IMAGE_SEND_TIMEOUT_EN
          terr_d  = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      sr_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef IMAGE_SEND_TIMEOUT_EN
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      sr_q    <= sr_d;
      done_q  <= done_d;
`ifdef IMAGE_SEND_TIMEOUT_EN
      terr_q  <= terr_d;
`endif
    end
  end

  // Muxed from registered state so reset blanks data_out without waiting for an edge.
  always_comb begin
    data_out = '0;
    if (state_q == ST_SEND) begin
      data_out = pix_in[int'(src_q)*PIX_W +: PIX_W];
    end
  end

  assign sender_reset = sr_q;
  assign seq_state    = state_q;
  assign src_idx      = src_q;
  assign done         = done_q;
`ifdef IMAGE_SEND_TIMEOUT_EN
  assign timeout_err  = terr_q;
`else
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_image_send_sequencer.sv
// Bench for image_send_sequencer: random and directed stimulus, reference model, scoreboard.
// Latency: expected values are queued per clock and compared on the falling edge.
// Backpressure: n/a.
module tb_image_send_sequencer;

  localparam int PIX_W   = 12;
  localparam int NUM_SRC = 3;
  localparam int RT      = 3;
  localparam int WT      = 4;
  localparam int TT      = 10;
  localparam int SRC_W   = $clog2(NUM_SRC) + 1;
  localparam logic [3:0] TBL = 4'b0100;
`ifdef IMAGE_SEND_TIMEOUT_EN
  localparam int TO_EN = 1;
`else
  localparam int TO_EN = 0;
`endif

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_SRC*PIX_W-1:0] pix_in;
  logic [3:0]               state;
  logic                     image_ready;
  logic [PIX_W-1:0]         data_out;
  logic                     sender_reset;
  logic [1:0]               seq_state;
  logic [SRC_W-1:0]         src_idx;
  logic                     done;
  logic                     timeout_err;

  image_send_sequencer #(
    .PIX_W(PIX_W), .NUM_SRC(NUM_SRC), .WAIT_TIME(WT), .RESET_TIME(RT),
    .TIMEOUT_TIME(TT), .TABLE_STATE(TBL)
  ) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .state(state),
    .image_ready(image_ready), .data_out(data_out), .sender_reset(sender_reset),
    .seq_state(seq_state), .src_idx(src_idx), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int src;
    int sr;
    int dn;
    int te;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  // Reference model: phase name, source number and cycles spent in the phase.
  int m_st, m_src, m_age, m_te, m_dn;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int slice(input int idx);
    logic [NUM_SRC*PIX_W-1:0] p;
    p = pix_in;
    return int'(p[idx*PIX_W +: PIX_W]);
  endfunction

  task automatic model_reset();
    m_st = 0; m_src = 0; m_age = 0; m_te = 0; m_dn = 0;
  endtask

  // 0 idle, 1 send, 2 gap, 3 finish. Send spends RT cycles in reset hold first.
  task automatic model_step(input logic [3:0] s, input logic r);
    bit trig;
    int lows;
    trig = (s == TBL);
    m_dn = 0;
    case (m_st)
      0: if (trig) begin m_st = 1; m_src = 0; m_age = 0; end
      1: begin
        if (!trig) begin
          m_st = 0; m_src = 0;
        end else if (m_age < RT) begin
          m_age++;
        end else begin
          lows = m_age - RT + 1;
          if (r) begin
            if (m_src < NUM_SRC - 1) begin m_st = 2; m_age = 0; end
            else begin m_st = 3; m_dn = 1; end
          end else if (TO_EN != 0 && lows >= TT) begin
            m_st = 3; m_te = 1;
          end else begin
            m_age++;
          end
        end
      end
      2: begin
        if (!trig) begin m_st = 0; m_src = 0; end
        else if (m_age + 1 == WT) begin m_st = 1; m_src++; m_age = 0; end
        else m_age++;
      end
      default: if (!trig) begin m_st = 0; m_src = 0; m_te = 0; end
    endcase
  endtask

  task automatic push_exp();
    exp_t e;
    e.st  = m_st;
    e.src = m_src;
    e.sr  = (m_st == 1) ? int'(m_age < RT) : 1;
    e.dn  = m_dn;
    e.te  = m_te;
    sb_q.push_back(e);
  endtask

  // Called 2 time units after a rising edge; leaves at the same phase.
  task automatic step(input logic [3:0] s, input logic r);
    state = s;
    image_ready = r;
    @(posedge clk);
    model_step(s, r);
    push_exp();
    #2;
  endtask

  // Ready pulse two cycles after the sender reset has been released.
  function automatic logic rdy_normal();
    return (m_st == 1 && m_age == RT + 2);
  endfunction

  // Monitor: one expected entry per clock, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("seq_state", int'(seq_state), e.st);
        check("src_idx", int'(src_idx), e.src);
        check("sender_reset", int'(sender_reset), e.sr);
        check("done", int'(done), e.dn);
        check("timeout_err", int'(timeout_err), e.te);
        check("data_out", int'(data_out), (e.st == 1) ? slice(e.src) : 0);
      end
    end
  end

  initial begin
    bit hit;
    int dc0;
    logic [63:0] rv;
    logic [3:0] s;

    reset = 1'b1;
    state = 4'b0000;
    image_ready = 1'b0;
    pix_in = {12'hCCC, 12'hBBB, 12'hAAA};
    model_reset();
    #2;
    check("rst_seq_state", int'(seq_state), 0);
    check("rst_src_idx", int'(src_idx), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_sender_reset", int'(sender_reset), 1);
    check("rst_done", int'(done), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Normal sequence: AAA, BBB, CCC with ready two cycles after release.
    dc0 = done_cnt;
    for (int i = 0; i < 45; i++) step(TBL, rdy_normal());
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    check("normal_done_pulses", done_cnt - dc0, 1);

    // Early ready: held high, each SEND lasts RT+1 cycles.
    dc0 = done_cnt;
    for (int i = 0; i < 30; i++) step(TBL, 1'b1);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    check("early_done_pulses", done_cnt - dc0, 1);

    // Abort inside the gap after source 0.
    dc0 = done_cnt;
    hit = 1'b0;
    for (int n = 0; n < 60 && !hit; n++) begin
      step(TBL, rdy_normal());
      if (m_st == 2 && m_src == 0 && m_age == 1) hit = 1'b1;
    end
    check("abort_in_gap", int'(seq_state), 2);
    step(4'b0001, 1'b0);
    check("abort_to_idle", int'(seq_state), 0);
    step(4'b0001, 1'b0);
    check("abort_no_done", done_cnt - dc0, 0);

    // Retrigger starts again at source 0.
    step(TBL, 1'b0);
    step(TBL, 1'b0);
    check("retrigger_data", int'(data_out), 12'hAAA);
    for (int i = 0; i < 8; i++) step(TBL, rdy_normal());

    // Asynchronous reset in the middle of source 1.
    hit = 1'b0;
    for (int n = 0; n < 80 && !hit; n++) begin
      step(TBL, rdy_normal());
      if (m_st == 1 && m_src == 1 && m_age == 1) hit = 1'b1;
    end
    check("arst_reach_src1", int'(src_idx), 1);
    #1;
    reset = 1'b1;
    sb_q.delete();
    #1;
    check("arst_seq_state", int'(seq_state), 0);
    check("arst_src_idx", int'(src_idx), 0);
    check("arst_data_out", int'(data_out), 0);
    check("arst_sender_reset", int'(sender_reset), 1);
    check("arst_done", int'(done), 0);
    check("arst_timeout_err", int'(timeout_err), 0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) step(TBL, rdy_normal());
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);

    // Silent receiver.
    for (int i = 0; i < 25; i++) step(TBL, 1'b0);
    check("timeout_flag", int'(timeout_err), TO_EN);
    check("timeout_state", int'(seq_state), (TO_EN != 0) ? 3 : 1);
    step(4'b0001, 1'b0);
    check("timeout_clear", int'(timeout_err), 0);
    step(4'b0001, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        rv = {$urandom(), $urandom()};
        pix_in = rv[NUM_SRC*PIX_W-1:0];
      end
      s = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : TBL;
      step(s, ($urandom_range(0, 4) == 0));
    end
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    @(negedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/image_send_sequencer.md
IMAGE_SEND_SEQUENCER -- requirements
Module: image_send_sequencer

Interface
REQ-001 SHALL have parameter PIX_W, default 12, meaning pixel width in bits.
REQ-002 SHALL have parameter NUM_SRC, default 2, meaning number of image sources sent in sequence (legal range 1..8).
REQ-003 SHALL have parameter WAIT_TIME, default 50_000_000, meaning inter-image gap in clk cycles (at least 1).
REQ-004 SHALL have parameter RESET_TIME, default 50_000_000, meaning sender-reset hold in clk cycles at the start of each image (at least 1).
REQ-005 SHALL have parameter TIMEOUT_TIME, default 500_000_000, meaning the maximum number of cycles to wait for image_ready.
REQ-006 SHALL have parameter TABLE_STATE, default 4'b0100, meaning the robot state that triggers a send sequence.
REQ-007 SHALL have one clock; reset is asynchronous and active-high.
REQ-008 SHALL have port clk, input, 1 bit: 50 MHz system clock.
REQ-009 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-010 SHALL have port pix_in, input, NUM_SRC*PIX_W bits: source k occupies bits [k*PIX_W +: PIX_W].
REQ-011 SHALL have port state, input, 4 bits: robot state.
REQ-012 SHALL have port image_ready, input, 1 bit: Arduino frame-received flag.
REQ-013 SHALL have port data_out, output, PIX_W bits: selected pixel.
REQ-014 SHALL have port sender_reset, output, 1 bit: Arduino sender reset.
REQ-015 SHALL have port seq_state, output, 2 bits: IDLE=0, SEND=1, GAP=2, FINISH=3.
REQ-016 SHALL have port src_idx, output, $clog2(NUM_SRC)+1 bits: current source index.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse on normal completion.
REQ-018 SHALL have port timeout_err, output, 1 bit: sticky timeout flag.

Function
REQ-019 IDLE SHALL go to SEND with src_idx=0 on the cycle after state==TABLE_STATE is sampled.
REQ-020 On each SEND entry, sender_reset SHALL be 1 for exactly RESET_TIME cycles and then 0 until SEND exits.
REQ-021 While sender_reset=1 in SEND, image_ready SHALL be ignored.
REQ-022 When image_ready=1 is sampled with sender_reset=0: if src_idx<NUM_SRC-1, the next state SHALL be GAP; otherwise it SHALL be FINISH with done=1 for that one cycle.
REQ-023 GAP SHALL last exactly WAIT_TIME cycles, then enter SEND with src_idx incremented by 1.
REQ-024 FINISH SHALL hold until state!=TABLE_STATE is sampled, then return to IDLE.
REQ-025 If state!=TABLE_STATE is sampled in SEND or GAP, the block SHALL abort to IDLE next cycle, with no done pulse.
REQ-026 data_out SHALL equal pix_in slice [src_idx] in SEND (including the reset hold) and 0 in all other states.
REQ-027 sender_reset SHALL be 1 in IDLE, GAP and FINISH.
REQ-028 Counters SHALL saturate rather than wrap; width SHALL be $clog2(max(WAIT_TIME, RESET_TIME, TIMEOUT_TIME))+1.
REQ-029 With NUM_SRC=1, the block SHALL never enter GAP.
REQ-030 src_idx SHALL be 0 in IDLE.

Reset
REQ-031 reset=1 SHALL force IDLE asynchronously: src_idx=0, counters=0, data_out=0, sender_reset=1, done=0, timeout_err=0, seq_state=0.
REQ-032 Reset asserted mid-SEND SHALL discard progress; the next sequence SHALL restart at source 0.

Configuration
REQ-033 With IMAGE_SEND_TIMEOUT_EN defined: in SEND, once sender_reset=0, a cycle count SHALL be kept. If it reaches TIMEOUT_TIME without image_ready, timeout_err SHALL be set to 1 and the block SHALL enter FINISH with no done pulse. timeout_err SHALL clear on IDLE entry or on reset.
REQ-034 Without IMAGE_SEND_TIMEOUT_EN: timeout_err SHALL be tied to 0, TIMEOUT_TIME SHALL be unused, and SEND SHALL wait indefinitely.

Structure
REQ-035 Package image_send_pkg SHALL hold the seq_state enum typedef, the state codes and the TABLE_STATE default constant.
REQ-036 A sub-module image_send_timer SHALL be used: a loadable, saturating down-counter with start, load value and expired ports. It is instantiated once and shared by the reset hold, the gap and the timeout.

Verification (NUM_SRC=3, RESET_TIME=3, WAIT_TIME=4, TIMEOUT_TIME=10, PIX_W=12)
REQ-037 Normal sequence: state=4'b0100, pix_in={12'hCCC,12'hBBB,12'hAAA}, image_ready pulsed 2 cycles after each reset release -> data_out AAA, then BBB, then CCC. sender_reset low 3 cycles after each SEND entry. Each GAP exactly 4 cycles. done is a single pulse on FINISH entry.
REQ-038 Early ready: image_ready held 1 throughout -> ignored during each 3-cycle hold; each SEND lasts exactly 4 cycles.
REQ-039 Abort: state changes to 4'b0001 during the GAP after source 0 -> IDLE next cycle, src_idx=0, done never asserts. A retrigger starts again at AAA.
REQ-040 Timeout (macro defined): image_ready held 0 -> timeout_err=1 ten cycles after reset release, then FINISH. timeout_err clears on IDLE entry. With the macro undefined, the block stays in SEND and timeout_err=0.
REQ-041 Async reset pulsed mid-SEND of source 1 -> all outputs at reset values immediately, before the next clk edge.
